// File: rtl/tv_cmd_arbiter.sv
// TV channel command arbiter: front-panel keys with hold/auto-repeat,
// remote commands with a post-command lockout window.
module tv_cmd_arbiter #(
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 200,
  parameter int GAP_TICKS    = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       pnl_up,
  input  logic       pnl_down,
  input  logic       rmt_valid,
  input  logic [1:0] rmt_cmd,
  output logic       rmt_ready,
  output logic       cmd_up,
  output logic       cmd_down,
  output logic [1:0] src,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE, HOLD, REPEAT, GAP
  } state_t;

  localparam logic [15:0] HoldLast = 16'(HOLD_TICKS - 1);
  localparam logic [15:0] RepLast  = 16'(REPEAT_TICKS - 1);
  localparam logic [15:0] GapLast  = 16'(GAP_TICKS - 1);

  state_t      state;
  logic [15:0] cnt;
  logic        dirUp;
  logic        press;
  logic        pressUp;
  logic [15:0] lastCnt;

  assign press   = pnl_up ^ pnl_down;
  assign pressUp = pnl_up & ~pnl_down;
  assign lastCnt = (state == HOLD) ? HoldLast : RepLast;

  // Panel has priority: remote is only taken in IDLE with no key down
  assign rmt_ready = (state == IDLE) && !press;
  assign busy      = (state != IDLE);

  always_comb begin
    src = 2'b00;
    unique case (state)
      HOLD, REPEAT: src = 2'b01;
      GAP:          src = 2'b10;
      default:      src = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      dirUp    <= 1'b0;
      cmd_up   <= 1'b0;
      cmd_down <= 1'b0;
    end else begin
      cmd_up   <= 1'b0;
      cmd_down <= 1'b0;
      unique case (state)
        IDLE: begin
          if (press) begin
            cmd_up   <= pressUp;
            cmd_down <= ~pressUp;
            dirUp    <= pressUp;
            state    <= HOLD;
            cnt      <= '0;
          end else if (rmt_valid) begin
            unique case (rmt_cmd)
              2'b01: begin
                cmd_up <= 1'b1;
                state  <= GAP;
                cnt    <= '0;
              end
              2'b10: begin
                cmd_down <= 1'b1;
                state    <= GAP;
                cnt      <= '0;
              end
              default: ;
            endcase
          end
        end
        HOLD, REPEAT: begin
          // Release or direction flip ends the session silently
          if (!press || (pressUp != dirUp)) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (tick) begin
            if (cnt == lastCnt) begin
              cmd_up   <= dirUp;
              cmd_down <= ~dirUp;
              state    <= REPEAT;
              cnt      <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        GAP: begin
          if (tick) begin
            if (cnt == GapLast) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tv_cmd_arbiter.sv
// Bench for tv_cmd_arbiter: directed scenarios plus random traffic,
// compared against a tick-counting model of owner/pulse behaviour.
module tb_tv_cmd_arbiter;

  localparam int H = 3;
  localparam int R = 2;
  localparam int G = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       pnl_up = 1'b0;
  logic       pnl_down = 1'b0;
  logic       rmt_valid = 1'b0;
  logic [1:0] rmt_cmd = 2'b00;
  logic       rmt_ready;
  logic       cmd_up;
  logic       cmd_down;
  logic [1:0] src;
  logic       busy;

  int nRun  = 0;
  int nFail = 0;

  // Model: owner 0 none, 1 panel, 2 remote; ticks counted since ownership began
  int   mOwner = 0;
  int   mTicks = 0;
  bit   mDir = 1'b0;
  bit   mUp = 1'b0;
  bit   mDown = 1'b0;
  bit   expReady;
  logic obsReady;
  logic obsUp;
  logic obsDown;
  logic obsBusy;
  logic [1:0] obsSrc;

  tv_cmd_arbiter #(
    .HOLD_TICKS(H),
    .REPEAT_TICKS(R),
    .GAP_TICKS(G)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .pnl_up(pnl_up),
    .pnl_down(pnl_down),
    .rmt_valid(rmt_valid),
    .rmt_cmd(rmt_cmd),
    .rmt_ready(rmt_ready),
    .cmd_up(cmd_up),
    .cmd_down(cmd_down),
    .src(src),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void modelStep();
    bit press;
    press = pnl_up ^ pnl_down;
    mUp = 1'b0;
    mDown = 1'b0;
    case (mOwner)
      0: begin
        if (press) begin
          mOwner = 1;
          mDir = pnl_up;
          mTicks = 0;
          mUp = pnl_up;
          mDown = pnl_down;
        end else if (rmt_valid && (rmt_cmd == 2'b01 || rmt_cmd == 2'b10)) begin
          mOwner = 2;
          mTicks = 0;
          mUp = (rmt_cmd == 2'b01);
          mDown = (rmt_cmd == 2'b10);
        end
      end
      1: begin
        if (!press || (pnl_up != mDir)) begin
          mOwner = 0;
        end else if (tick) begin
          mTicks++;
          if (mTicks == H || (mTicks > H && (mTicks - H) % R == 0)) begin
            mUp = mDir;
            mDown = !mDir;
          end
        end
      end
      default: begin
        if (tick) begin
          mTicks++;
          if (mTicks == G) mOwner = 0;
        end
      end
    endcase
  endfunction

  // Drives one clock of inputs from a falling edge to the next one
  task automatic stepCycle(input bit r, input bit u, input bit d,
                           input bit v, input bit [1:0] c, input bit t);
    rst = r;
    pnl_up = u;
    pnl_down = d;
    rmt_valid = v;
    rmt_cmd = c;
    tick = t;
    if (r) begin
      mOwner = 0;
      mTicks = 0;
      mUp = 1'b0;
      mDown = 1'b0;
    end
    expReady = (mOwner == 0) && !(u ^ d);
    #1;
    obsReady = rmt_ready;
    obsUp = cmd_up;
    obsDown = cmd_down;
    obsSrc = src;
    obsBusy = busy;
    @(posedge clk);
    if (!r) modelStep();
    @(negedge clk);
  endtask

  task automatic settle();
    for (int i = 0; i < 6; i++) stepCycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
  endtask

  task automatic test_reset();
    stepCycle(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    nRun++;
    if ({obsUp, obsDown, obsSrc, obsBusy, obsReady} !== 6'b000001) begin
      nFail++;
      $display("FAIL reset_async: got up%b dn%b src%b busy%b rdy%b want 0 0 00 0 1",
               obsUp, obsDown, obsSrc, obsBusy, obsReady);
    end
    stepCycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    nRun++;
    if ({cmd_up, cmd_down, src, busy, obsReady} !== 6'b000001) begin
      nFail++;
      $display("FAIL reset_idle: got up%b dn%b src%b busy%b rdy%b want 0 0 00 0 1",
               cmd_up, cmd_down, src, busy, obsReady);
    end
  endtask

  task automatic test_hold_repeat();
    int pulses[$];
    int expIdx[5] = '{0, 11, 19, 27, 35};
    int downs = 0;
    int modelErr = 0;
    settle();
    for (int i = 0; i < 40; i++) begin
      stepCycle(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, (i % 4) == 3);
      if ({obsReady, cmd_up, cmd_down, src, busy} !==
          {expReady, mUp, mDown, 2'(mOwner), mOwner != 0}) modelErr++;
      if (cmd_up === 1'b1) pulses.push_back(i);
      if (cmd_down !== 1'b0) downs++;
    end
    nRun++;
    if (modelErr != 0) begin
      nFail++;
      $display("FAIL hold_model: %0d cycles differ, want 0", modelErr);
    end
    nRun++;
    if (pulses.size() != 5 || downs != 0) begin
      nFail++;
      $display("FAIL hold_count: up pulses %0d down %0d, want 5 and 0",
               pulses.size(), downs);
    end else begin
      for (int k = 0; k < 5; k++) begin
        nRun++;
        if (pulses[k] != expIdx[k]) begin
          nFail++;
          $display("FAIL hold_pulse%0d: at clk %0d, want clk %0d",
                   k, pulses[k], expIdx[k]);
        end
      end
    end
  endtask

  task automatic test_remote();
    int lowCnt = 0;
    settle();
    stepCycle(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
    nRun++;
    if ({obsReady, cmd_down, cmd_up, src} !== 5'b11010) begin
      nFail++;
      $display("FAIL remote_accept: got rdy%b dn%b up%b src%b want 1 1 0 10",
               obsReady, cmd_down, cmd_up, src);
    end
    for (int i = 0; i < 6; i++) begin
      stepCycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
      if (obsReady === 1'b0) lowCnt++;
      nRun++;
      if ({obsReady, cmd_up, cmd_down, src, busy} !==
          {expReady, mUp, mDown, 2'(mOwner), mOwner != 0}) begin
        nFail++;
        $display("FAIL remote_gap: cyc %0d got %b want %b", i,
                 {obsReady, cmd_up, cmd_down, src, busy},
                 {expReady, mUp, mDown, 2'(mOwner), mOwner != 0});
      end
    end
    nRun++;
    if (lowCnt != G) begin
      nFail++;
      $display("FAIL remote_lockout: ready low %0d clks, want %0d", lowCnt, G);
    end
  endtask

  task automatic test_priority();
    int ups = 0;
    settle();
    stepCycle(1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0);
    nRun++;
    if ({obsReady, cmd_down, cmd_up, src} !== 5'b01001) begin
      nFail++;
      $display("FAIL prio_panel: got rdy%b dn%b up%b src%b want 0 1 0 01",
               obsReady, cmd_down, cmd_up, src);
    end
    for (int i = 0; i < 8; i++) begin
      stepCycle(1'b0, 1'b0, 1'b1, 1'b1, 2'b01, i[0]);
      if (obsReady !== 1'b0 || cmd_up !== 1'b0) ups++;
    end
    nRun++;
    if (ups != 0) begin
      nFail++;
      $display("FAIL prio_hold: remote leaked %0d clks, want 0", ups);
    end
    stepCycle(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    stepCycle(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    nRun++;
    if ({obsReady, cmd_up, cmd_down, src} !== 5'b11010) begin
      nFail++;
      $display("FAIL prio_release: got rdy%b up%b dn%b src%b want 1 1 0 10",
               obsReady, cmd_up, cmd_down, src);
    end
  endtask

  task automatic test_both_keys();
    int bad = 0;
    settle();
    for (int i = 0; i < 4; i++) begin
      stepCycle(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
      if ({obsReady, cmd_up, cmd_down, busy} !== 4'b1000) bad++;
    end
    nRun++;
    if (bad != 0) begin
      nFail++;
      $display("FAIL both_keys: %0d bad clks, want 0", bad);
    end
  endtask

  task automatic test_switch();
    settle();
    stepCycle(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    stepCycle(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    stepCycle(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    nRun++;
    if ({cmd_up, cmd_down, busy} !== 3'b000) begin
      nFail++;
      $display("FAIL switch_idle: got up%b dn%b busy%b want 0 0 0",
               cmd_up, cmd_down, busy);
    end
    stepCycle(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    nRun++;
    if ({cmd_up, cmd_down, busy} !== 3'b011) begin
      nFail++;
      $display("FAIL switch_down: got up%b dn%b busy%b want 0 1 1",
               cmd_up, cmd_down, busy);
    end
    for (int i = 1; i <= H; i++) begin
      stepCycle(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1);
      nRun++;
      if (cmd_down !== (i == H)) begin
        nFail++;
        $display("FAIL switch_cnt: tick %0d dn%b want %b", i, cmd_down, i == H);
      end
    end
  endtask

  task automatic test_reset_mid();
    settle();
    for (int i = 0; i < 6; i++) stepCycle(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    stepCycle(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    nRun++;
    if ({obsUp, obsDown, obsSrc, obsBusy, obsReady} !== 6'b000000) begin
      nFail++;
      $display("FAIL rst_mid: got up%b dn%b src%b busy%b rdy%b want all 0",
               obsUp, obsDown, obsSrc, obsBusy, obsReady);
    end
    stepCycle(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    nRun++;
    if ({cmd_up, cmd_down, src} !== 4'b1001) begin
      nFail++;
      $display("FAIL rst_repress: got up%b dn%b src%b want 1 0 01",
               cmd_up, cmd_down, src);
    end
  endtask

  task automatic test_random();
    bit u = 1'b0;
    bit d = 1'b0;
    int modelErr = 0;
    int overlap = 0;
    settle();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) u = ~u;
      if ($urandom_range(9) == 0) d = ~d;
      stepCycle($urandom_range(199) == 0, u, d, 1'($urandom),
                2'($urandom), $urandom_range(2) == 0);
      if ({obsReady, cmd_up, cmd_down, src, busy} !==
          {expReady, mUp, mDown, 2'(mOwner), mOwner != 0}) begin
        modelErr++;
        if (modelErr < 5)
          $display("FAIL random_cyc: cyc %0d got %b want %b", i,
                   {obsReady, cmd_up, cmd_down, src, busy},
                   {expReady, mUp, mDown, 2'(mOwner), mOwner != 0});
      end
      if (cmd_up === 1'b1 && cmd_down === 1'b1) overlap++;
    end
    nRun++;
    if (modelErr != 0) begin
      nFail++;
      $display("FAIL random_model: %0d cycles differ, want 0", modelErr);
    end
    nRun++;
    if (overlap != 0) begin
      nFail++;
      $display("FAIL random_excl: both pulses high %0d clks, want 0", overlap);
    end
  endtask

  initial begin
    test_reset();
    test_hold_repeat();
    test_remote();
    test_priority();
    test_both_keys();
    test_switch();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

endmodule
